// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared constants for the PIO state-machine sequencer and dividers
package pio_pkg;

  localparam int NUM_SM_DEFAULT = 4;

  // CTRL fields are NUM_SM bits wide; these are field indices, the bit offset is index*NUM_SM
  localparam int ENABLE_LSB         = 0;
  localparam int RESTART_LSB        = 1;
  localparam int CLKDIV_RESTART_LSB = 2;

  localparam int INT_MSB  = 31;
  localparam int INT_LSB  = 16;
  localparam int FRAC_MSB = 15;
  localparam int FRAC_LSB = 8;

  localparam int CLKDIV_INT_RST  = 1;
  localparam int CLKDIV_FRAC_RST = 0;

endpackage

// File: rtl/pio_clkdiv.sv
// rtl/pio_clkdiv.sv - fractional clock-enable divider for one state machine
module pio_clkdiv
  import pio_pkg::*;
#(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        restart,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic        penable
);

  logic [INT_W-1:0]  int_q;
  logic [FRAC_W-1:0] frac_q;
  logic [FRAC_W-1:0] acc_q;
  logic [INT_W:0]    cnt_q;
  logic [INT_W:0]    int_eff;
  logic [FRAC_W:0]   sum;
  logic              unused_wdata;

  assign unused_wdata = ^wdata[FRAC_LSB-1:0];

  // A zero integer field means the full 2^INT_W period, hence the extra counter bit
  assign int_eff = (int_q == '0) ? {1'b1, {INT_W{1'b0}}} : {1'b0, int_q};
  assign sum     = {1'b0, acc_q} + {1'b0, frac_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_q   <= INT_W'(CLKDIV_INT_RST);
      frac_q  <= FRAC_W'(CLKDIV_FRAC_RST);
      acc_q   <= '0;
      cnt_q   <= (INT_W+1)'(1);
      penable <= 1'b0;
    end else begin
      if (wr) begin
        int_q  <= wdata[INT_LSB +: INT_W];
        frac_q <= wdata[FRAC_MSB -: FRAC_W];
      end
      if (restart) begin
        cnt_q   <= (INT_W+1)'(1);
        acc_q   <= '0;
        penable <= 1'b0;
      end else if (!en) begin
        penable <= 1'b0;
      end else if (cnt_q == (INT_W+1)'(1)) begin
        penable <= 1'b1;
        acc_q   <= sum[FRAC_W-1:0];
        cnt_q   <= int_eff + {{INT_W{1'b0}}, sum[FRAC_W]};
      end else begin
        penable <= 1'b0;
        cnt_q   <= cnt_q - (INT_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/pio_sm_sequencer.sv
// rtl/pio_sm_sequencer.sv - CTRL register, restart pulses and per-SM clock-enable dividers
module pio_sm_sequencer
  import pio_pkg::*;
#(
  parameter int NUM_SM = NUM_SM_DEFAULT,
  parameter int INT_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ctrl_wr,
  input  logic [3*NUM_SM-1:0]   ctrl_wdata,
  input  logic [NUM_SM-1:0]     clkdiv_wr,
  input  logic [31:0]           clkdiv_wdata,
  output logic [NUM_SM-1:0]     sm_enable,
  output logic [NUM_SM-1:0]     sm_restart,
  output logic [NUM_SM-1:0]     penable,
  output logic [NUM_SM-1:0]     ctrl_rdata
);

  logic [NUM_SM-1:0] div_restart;

  assign div_restart = ctrl_wr ? ctrl_wdata[CLKDIV_RESTART_LSB*NUM_SM +: NUM_SM] : '0;
  assign ctrl_rdata  = sm_enable;

  // Restart is a pure pulse: it only lasts while the write that set it is the latest edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sm_enable  <= '0;
      sm_restart <= '0;
    end else begin
      if (ctrl_wr) begin
        sm_enable <= ctrl_wdata[ENABLE_LSB*NUM_SM +: NUM_SM];
      end
      sm_restart <= ctrl_wr ? ctrl_wdata[RESTART_LSB*NUM_SM +: NUM_SM] : '0;
    end
  end

  // Dividers see the registered enable, so a new enable takes effect one edge later
  for (genvar i = 0; i < NUM_SM; i++) begin : g_div
    pio_clkdiv #(
      .INT_W  (INT_W),
      .FRAC_W (FRAC_W)
    ) u_clkdiv (
      .clk     (clk),
      .reset   (reset),
      .en      (sm_enable[i]),
      .restart (div_restart[i]),
      .wr      (clkdiv_wr[i]),
      .wdata   (clkdiv_wdata),
      .penable (penable[i])
    );
  end

endmodule

// File: tb/tb_pio_sm_sequencer.sv
// tb/tb_pio_sm_sequencer.sv - scoreboard bench for pio_sm_sequencer
module tb_pio_sm_sequencer;

  localparam logic [15:0] ALL = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        ctrl_wr;
  logic [11:0] ctrl_wdata;
  logic [3:0]  clkdiv_wr;
  logic [31:0] clkdiv_wdata;
  logic [3:0]  sm_enable, sm_restart, penable, ctrl_rdata;

  pio_sm_sequencer #(.NUM_SM(4), .INT_W(16), .FRAC_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .ctrl_wr      (ctrl_wr),
    .ctrl_wdata   (ctrl_wdata),
    .clkdiv_wr    (clkdiv_wr),
    .clkdiv_wdata (clkdiv_wdata),
    .sm_enable    (sm_enable),
    .sm_restart   (sm_restart),
    .penable      (penable),
    .ctrl_rdata   (ctrl_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] mask;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] obs;

  assign obs = {ctrl_rdata, sm_restart, sm_enable, penable};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mk(input logic [3:0] rst, input logic [3:0] en, input logic [3:0] pen);
    return {en, rst, en, pen};
  endfunction

  task automatic push(input int c, input logic [15:0] m, input logic [15:0] e, input string nm);
    exp_t x;
    x.cyc = c; x.mask = m; x.exp = e; x.name = nm;
    q.push_back(x);
  endtask

  // Monitor: compares every expectation due after the current edge
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t x;
      x = q.pop_front();
      n_checks++;
      if (x.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: check for cycle %0d missed at cycle %0d", x.name, x.cyc, cyc);
      end else if ((obs & x.mask) !== (x.exp & x.mask)) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got %h expected %h (mask %h)", x.name, cyc, obs & x.mask, x.exp & x.mask, x.mask);
      end
    end
  end

  task automatic step(input logic cw, input logic [11:0] cd, input logic [3:0] dw, input logic [31:0] dd);
    ctrl_wr = cw; ctrl_wdata = cd; clkdiv_wr = dw; clkdiv_wdata = dd;
    @(posedge clk); #1;
    ctrl_wr = 1'b0; clkdiv_wr = '0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int n;
    int pulses;
    reset = 1'b1; ctrl_wr = 1'b0; ctrl_wdata = '0; clkdiv_wr = '0; clkdiv_wdata = '0;
    wait_cycles(3);
    push(cyc, ALL, 16'h0, "reset_state");
    reset = 1'b0;
    wait_cycles(1);

    // Divisor 1.0 from reset on SM0
    step(1'b1, 12'h001, 4'b0000, 32'h0);
    n = cyc;
    push(n, ALL, mk(4'h0, 4'h1, 4'h0), "t1_enable");
    for (int k = 1; k <= 5; k++) push(n + k, ALL, mk(4'h0, 4'h1, 4'h1), "t1_div1");
    wait_cycles(5);

    // SM1 INT=3 written in the same cycle as its clkdiv_restart
    step(1'b1, 12'h203, 4'b0010, 32'h0003_0000);
    n = cyc;
    push(n, ALL, mk(4'h0, 4'h3, 4'b0001), "t2_restart");
    for (int k = 1; k <= 9; k++)
      push(n + k, ALL, mk(4'h0, 4'h3, {2'b00, ((k - 1) % 3 == 0), 1'b1}), "t2_div3");
    wait_cycles(9);

    // SM2 divisor 1.5: 1,1,0 pattern, 200 pulses in 300 cycles
    step(1'b0, 12'h000, 4'b0100, 32'h0001_8000);
    step(1'b1, 12'h407, 4'b0000, 32'h0);
    n = cyc;
    push(n, 16'h00F4, mk(4'h0, 4'h7, 4'h0), "t3_restart");
    for (int k = 1; k <= 300; k++)
      push(n + k, 16'h0004, {13'b0, ((k - 1) % 3 != 2), 2'b00}, "t3_div1p5");
    pulses = 0;
    repeat (300) begin
      @(posedge clk); @(negedge clk);
      pulses += int'(penable[2]);
    end
    n_checks++;
    if (pulses != 200) begin
      n_fail++;
      $display("FAIL t3_pulse_count: got %0d expected 200", pulses);
    end
    @(posedge clk); #1;

    // Restart pulses with everything disabled
    step(1'b1, 12'h000, 4'b0000, 32'h0);
    n = cyc;
    push(n + 1, ALL, 16'h0, "t4_disabled");
    wait_cycles(1);
    step(1'b1, 12'h0A0, 4'b0000, 32'h0);
    n = cyc;
    push(n, ALL, mk(4'hA, 4'h0, 4'h0), "t4_restart_pulse");
    push(n + 1, ALL, 16'h0, "t4_selfclear");
    push(n + 2, ALL, 16'h0, "t4_idle");
    wait_cycles(2);

    // SM1 (INT=3) disabled mid-period resumes its frozen phase
    step(1'b1, 12'h202, 4'b0000, 32'h0);
    n = cyc;
    push(n, ALL, mk(4'h0, 4'h2, 4'h0), "t5_start");
    push(n + 1, ALL, mk(4'h0, 4'h2, 4'h2), "t5_first");
    wait_cycles(1);
    step(1'b1, 12'h000, 4'b0000, 32'h0);
    push(n + 2, ALL, 16'h0, "t5_disable");
    push(n + 3, ALL, 16'h0, "t5_frozen");
    wait_cycles(2);
    step(1'b1, 12'h002, 4'b0000, 32'h0);
    n = cyc;
    push(n, ALL, mk(4'h0, 4'h2, 4'h0), "t5_reenable");
    push(n + 1, ALL, mk(4'h0, 4'h2, 4'h0), "t5_resume0");
    push(n + 2, ALL, mk(4'h0, 4'h2, 4'h2), "t5_resume1");
    push(n + 3, ALL, mk(4'h0, 4'h2, 4'h0), "t5_resume2");
    push(n + 4, ALL, mk(4'h0, 4'h2, 4'h0), "t5_resume3");
    push(n + 5, ALL, mk(4'h0, 4'h2, 4'h2), "t5_resume4");
    wait_cycles(5);

    // SM3 INT=0 means a 65536-cycle period
    step(1'b1, 12'h808, 4'b1000, 32'h0000_0000);
    n = cyc;
    push(n, 16'h00F8, mk(4'h0, 4'h8, 4'h0), "t6_restart");
    push(n + 1, 16'h0008, 16'h0008, "t6_first");
    push(n + 2, 16'h0008, 16'h0000, "t6_gap");
    push(n + 65536, 16'h0008, 16'h0000, "t6_before");
    push(n + 65537, 16'h0008, 16'h0008, "t6_second");
    push(n + 65538, 16'h0008, 16'h0000, "t6_after");
    wait_cycles(65538);

    // SM0/SM1 INT=2 in anti-phase, then aligned by a shared clkdiv_restart
    step(1'b1, 12'h000, 4'b0011, 32'h0002_0000);
    wait_cycles(1);
    step(1'b1, 12'h202, 4'b0000, 32'h0);
    n = cyc;
    step(1'b1, 12'h103, 4'b0000, 32'h0);
    push(n + 1, ALL, mk(4'h0, 4'h3, 4'b0010), "t7_phase_a0");
    push(n + 2, ALL, mk(4'h0, 4'h3, 4'b0001), "t7_phase_b0");
    push(n + 3, ALL, mk(4'h0, 4'h3, 4'b0010), "t7_phase_a1");
    push(n + 4, ALL, mk(4'h0, 4'h3, 4'b0001), "t7_phase_b1");
    wait_cycles(3);
    step(1'b1, 12'h303, 4'b0000, 32'h0);
    n = cyc;
    push(n, ALL, mk(4'h0, 4'h3, 4'h0), "t7_align");
    for (int k = 1; k <= 6; k++)
      push(n + k, ALL, mk(4'h0, 4'h3, (k % 2 == 1) ? 4'b0011 : 4'b0000), "t7_aligned");
    wait_cycles(7);

    // Asynchronous reset mid-stream, then divisors are back to 1.0
    reset = 1'b1;
    push(cyc, ALL, 16'h0, "t8_reset_held");
    #1;
    n_checks++;
    if (obs !== 16'h0) begin
      n_fail++;
      $display("FAIL t8_reset_async: got %h expected 0000", obs);
    end
    wait_cycles(2);
    reset = 1'b0;
    step(1'b1, 12'h00F, 4'b0000, 32'h0);
    n = cyc;
    push(n, ALL, mk(4'h0, 4'hF, 4'h0), "t8_enable_all");
    for (int k = 1; k <= 3; k++) push(n + k, ALL, mk(4'h0, 4'hF, 4'hF), "t8_div1_after_reset");
    wait_cycles(3);

    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations never checked", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_sm_sequencer.md
Name: pio_sm_sequencer

Overview:
Per-state-machine control and clock-enable scheduler for the PIO block. It holds the CTRL register fields (SM_ENABLE, SM_RESTART, CLKDIV_RESTART) and one fractional clock divider per state machine. It drives each state machine's sm_enable, sm_restart and penable inputs. It sits between the PIO register file and the NUM_SM state_machine instances.

Parameters:
NUM_SM, 4, number of state machines sequenced
INT_W, 16, width of the integer divisor field
FRAC_W, 8, width of the fractional divisor field

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
ctrl_wr  in  1  write strobe for CTRL, one cycle
ctrl_wdata  in  3*NUM_SM  CTRL write data: [NUM_SM-1:0] enable, [2*NUM_SM-1:NUM_SM] restart, [3*NUM_SM-1:2*NUM_SM] clkdiv_restart
clkdiv_wr  in  NUM_SM  per-SM write strobe for SMx_CLKDIV
clkdiv_wdata  in  32  CLKDIV data: INT in [31:16], FRAC in [15:8], [7:0] ignored
sm_enable  out  NUM_SM  level enable to each state machine
sm_restart  out  NUM_SM  one-cycle restart pulse per state machine
penable  out  NUM_SM  registered per-SM clock-enable pulse
ctrl_rdata  out  NUM_SM  enable readback, equal to sm_enable

Behaviour:
- Reset values:
  - sm_enable=0, sm_restart=0, penable=0.
  - Per SM: INT=1, FRAC=0, cnt=1, acc=0.
- CTRL write:
  - On a clk edge with ctrl_wr=1: sm_enable <= wdata enable field. sm_restart <= wdata restart field.
  - sm_restart self-clears on the next edge unless ctrl_wr rewrites it. It is a pure pulse, independent of enable.
  - Restart/clkdiv_restart bits written as 0 have no effect.
- CLKDIV write: on clkdiv_wr[i], INT_i and FRAC_i load. cnt_i and acc_i are NOT disturbed. The new divisor applies from the next reload.
- Effective integer: INT_eff = (INT==0) ? 2^INT_W : INT. Hence cnt is INT_W+1 bits wide.
- Per-SM divider, evaluated on each clk edge, highest priority first:
  1. clkdiv_restart bit i set by the current ctrl_wr: cnt<=1, acc<=0, penable[i]<=0.
  2. sm_enable[i]=0: cnt and acc hold; penable[i]<=0.
  3. cnt==1: penable[i]<=1. {carry,acc}<=acc+FRAC (FRAC_W+1-bit sum). cnt<=INT_eff+carry.
  4. Otherwise: penable[i]<=0; cnt<=cnt-1.
- Average penable rate is 1/(INT+FRAC/256). The pattern is exact and repeatable after clkdiv_restart.
- Latency:
  - ctrl_wr enabling SM i at edge N gives sm_enable high after N.
  - penable[i] first goes high after edge N+1, provided cnt==1 (true after reset or restart).
- Disable mid-period: counter and accumulator freeze. On re-enable, the divider resumes the frozen phase and does not restart.
- Same cycle as ctrl_wr: clkdiv_restart together with enable=1 restarts the divider phase, and enable takes effect the same edge. The first penable therefore occurs after edge N+1.
- Multiple SMs restarted on the same ctrl_wr with equal divisors produce identical, phase-aligned penable streams thereafter.
- Simultaneous clkdiv_wr[i] and ctrl_wr with clkdiv_restart[i]: both apply. The reload after the restart uses the new INT/FRAC.
- Asynchronous reset mid-operation: all outputs return to reset values immediately, and all divisors revert to 1.0.

Decomposition:
- Shared package pio_pkg:
  - NUM_SM default and CTRL field offsets (ENABLE_LSB, RESTART_LSB, CLKDIV_RESTART_LSB).
  - CLKDIV field positions (INT_MSB=31, INT_LSB=16, FRAC_MSB=15, FRAC_LSB=8).
  - Reset constants CLKDIV_INT_RST=1, CLKDIV_FRAC_RST=0.
- One sub-module, pio_clkdiv: a single-SM fractional divider holding INT, FRAC, cnt and acc. Ports: clk, reset, en, restart, wr, wdata, penable. It is instantiated NUM_SM times via generate. The top level holds the CTRL register and the restart pulse logic.

Test Plan:
- Reset, then ctrl_wr enable=4'b0001 (divisor 1.0) -> sm_enable=0001. penable[0] high every cycle from the second edge on; penable[3:1]=0.
- clkdiv_wr[1] INT=3 FRAC=0, enable SM1 with clkdiv_restart[1] -> penable[1] pattern 1,0,0 repeating. The first 1 occurs one cycle after the write.
- SM2 with INT=1, FRAC=128 after restart -> penable[2] pattern 1,1,0 repeating, i.e. 2 pulses per 3 cycles. Over 300 cycles, exactly 200 pulses.
- SM3 INT=0 FRAC=0 -> penable[3] once every 65536 cycles.
- ctrl_wr restart=4'b1010 with enable=0 -> sm_restart=1010 for exactly one cycle. sm_enable and penable are unchanged (all 0).
- SM0 and SM1 at INT=2 with different phases; ctrl_wr clkdiv_restart=0011 -> penable[0]==penable[1] every cycle afterwards. Assert reset mid-stream -> all outputs 0 immediately.
